mem_arb_ctrl: RTL
=================

# mem_arb_ctrl

Two-port round-robin arbiter and access sequencer for the single-port 8-bit `memory` block. Two requesters (e.g. CPU-side and DMA-side) issue read or write transactions through a valid/ready handshake. The controller grants one at a time, drives the memory's `chip_en`/`read_write`/`address`/`data_in` for exactly one cycle, then returns read data to the owning requester after a fixed read latency. It sits directly in front of `memory`; nothing else drives the memory pins.

## Interface
- `AW`, 8, address width (matches `memory.address`)
- `DW`, 8, data width (matches `memory.data_in`/`data_out`)
- `RD_LAT`, 1, cycles from the chip-enable cycle to `data_out` valid; legal range 1..3
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid`  in  1  requester 0 has a transaction
- `req0_we`  in  1  1 = write, 0 = read
- `req0_addr`  in  AW  requester 0 address
- `req0_wdata`  in  DW  requester 0 write data
- `req0_ready`  out  1  transaction accepted this cycle
- `req0_rvalid`  out  1  one-cycle pulse; `req0_rdata` valid
- `req0_rdata`  out  DW  read data for requester 0
- `req1_*`  same set, for requester 1
- `mem_address`  out  AW  to `memory.address`
- `mem_data_in`  out  DW  to `memory.data_in`
- `mem_read_write`  out  1  to `memory.read_write`; 1 = write, 0 = read
- `mem_chip_en`  out  1  to `memory.chip_en`; active high
- `mem_data_out`  in  DW  from `memory.data_out`

## Operation
- FSM states:
  - IDLE: on any valid, go to ISSUE.
  - ISSUE: one cycle, `mem_chip_en`=1. A write goes to IDLE; a read goes to WAIT.
  - WAIT: `RD_LAT` cycles, counted by a 2-bit counter. After the last cycle, go to IDLE.
- Handshake:
  - A requester holds `valid` and its fields stable until it sees `ready`=1 on a rising edge.
  - `readyN` is combinational. It is high only in IDLE, only to the winner, and only when `reqN_valid`=1.
  - At acceptance the controller latches `we`, `addr`, `wdata` and the owner ID.
- Arbitration:
  - Round-robin with a 1-bit priority pointer. After a grant to N, priority goes to the other requester.
  - Only one valid: it wins regardless of the pointer.
  - The pointer resets to favour requester 0.
- Memory pins:
  - `mem_address`, `mem_data_in` and `mem_read_write` are registered and loaded at acceptance. They hold their last value outside ISSUE.
  - `mem_chip_en` is high only in ISSUE.
- Read return:
  - `mem_data_out` is captured on the edge ending the last WAIT cycle.
  - The captured value drives both `rdata` buses.
  - `rvalid` pulses for one cycle to the owner only.
  - `rdata` holds its value until the next read capture.
- Writes produce no `rvalid`.
- Reset (async, also mid-transaction):
  - All outputs go to 0 immediately: ready, rvalid, rdata, `mem_*`.
  - FSM goes to IDLE, the pointer goes to requester 0, and the WAIT counter is cleared.
  - An in-flight read is dropped with no `rvalid`. A requester still holding `valid` is re-arbitrated after reset release.

## Timing
- Acceptance cycle A (IDLE, `ready`=1); ISSUE is cycle A+1.
- Write: IDLE again at A+2. Back-to-back writes are accepted every 2 cycles.
- Read:
  - WAIT runs A+2 .. A+1+`RD_LAT`.
  - Capture happens at the end of A+1+`RD_LAT`.
  - `rvalid` is high in cycle A+2+`RD_LAT`. This is also an IDLE cycle, so a new acceptance may coincide with it.
- Read-to-read period: `RD_LAT`+2 cycles.
- A valid asserted while the controller is busy is held off (`ready`=0) with no loss. Arbitration runs in the next IDLE cycle.

## Test plan
- Reset values: assert `rst_n`=0 with random inputs → every output is 0; after release, `mem_chip_en` stays 0 until a valid arrives.
- Single write: req0 writes addr 0x3C, data 0xA5 → `req0_ready` at A, `mem_chip_en`=1/`mem_read_write`=1/`mem_address`=0x3C/`mem_data_in`=0xA5 in A+1 only, no `rvalid`.
- Read with `RD_LAT`=2: req1 reads 0x3C, memory model returns 0xA5 → `mem_chip_en`=1, `mem_read_write`=0 at A+1; `req1_rvalid` one cycle at A+4 with `req1_rdata`=0xA5; `req0_rvalid` stays 0.
- Round-robin: both requesters hold valid for 4 writes each → grants alternate 0,1,0,1,…, each accepted 2 cycles apart; no requester gets two consecutive grants while the other waits.
- Reset mid-read: assert `rst_n`=0 during WAIT → `mem_chip_en`=0 and `rvalid`=0 immediately; no `rvalid` ever appears for that read; after release, a pending req1 is re-granted.
- Back-to-back read then write: req0 read (`RD_LAT`=1) with req1 write pending → req1 accepted in the same cycle as `req0_rvalid` (A+3), and its ISSUE follows at A+4.

Source files
------------

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: two-port round-robin arbiter sequencing single-cycle accesses to a single-port memory,
// returning read data to the owning requester after RD_LAT cycles.
module mem_arb_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_read_write,
    output logic          mem_chip_en,
    input  logic [DW-1:0] mem_data_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t        state;
    logic          ptr;
    logic          owner;
    logic [1:0]    cnt;
    logic [DW-1:0] rdata;
    logic          win0;
    logic          win1;
    // A lone valid wins outright; on contention ptr picks (0 favours requester 0)
    assign win0 = req0_valid && (!req1_valid || !ptr);
    assign win1 = req1_valid && (!req0_valid || ptr);
    assign req0_ready = rst_n && state == IDLE && win0;
    assign req1_ready = rst_n && state == IDLE && win1;
    assign req0_rdata = rdata;
    assign req1_rdata = rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            owner          <= 1'b0;
            cnt            <= 2'd0;
            rdata          <= '0;
            req0_rvalid    <= 1'b0;
            req1_rvalid    <= 1'b0;
            mem_address    <= '0;
            mem_data_in    <= '0;
            mem_read_write <= 1'b0;
            mem_chip_en    <= 1'b0;
        end else begin
            mem_chip_en <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            case (state)
                IDLE: if (win0 || win1) begin
                    owner          <= win1;
                    ptr            <= win0;
                    mem_address    <= win1 ? req1_addr : req0_addr;
                    mem_data_in    <= win1 ? req1_wdata : req0_wdata;
                    mem_read_write <= win1 ? req1_we : req0_we;
                    mem_chip_en    <= 1'b1;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    state <= mem_read_write ? IDLE : WAIT;
                    cnt   <= 2'(RD_LAT - 1);
                end
                WAIT: if (cnt == 2'd0) begin
                    rdata       <= mem_data_out;
                    req0_rvalid <= !owner;
                    req1_rvalid <= owner;
                    state       <= IDLE;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
